// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned HDR_LEN = 2;
    localparam logic [7:0]  XOR_SEED = 8'h00;

    typedef enum logic [STATE_W-1:0] {
        ST_HDR0 = 3'd0,
        ST_HDR1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Byte-lane packer: collects four little-endian bytes; the word and its
// completion pulse are combinational so the loader can register them directly.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_c,
    output logic        word_done_c
);

    logic [1:0]  cnt_q;
    logic [23:0] lanes_q;

    assign word_done_c = en && (cnt_q == 2'd3);
    assign word_c      = {byte_data, lanes_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            lanes_q <= 24'd0;
        end else if (en) begin
            cnt_q <= cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    lanes_q[7:0]   <= byte_data;
                2'd1:    lanes_q[15:8]  <= byte_data;
                2'd2:    lanes_q[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: unpacks a counted byte stream into IM word writes and holds the
// core in reset until done. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    output logic        o_im_we,
    output logic [31:0] o_im_addr,
    output logic [31:0] o_im_wdata,
    output logic        o_cpu_rst_n,
    output logic        o_done,
    output logic        o_err
);

    localparam int unsigned IDX_W     = ADDR_W + 1;
    localparam logic [31:0] CAP_WORDS = 32'd1 << ADDR_W;

    state_t            state_q, state_n;
    logic [15:0]       n_q, n_n, n_full;
    logic [IDX_W-1:0]  idx_q, idx_n;
    logic              accept, pk_en;
    logic [31:0]       word_c;
    logic              word_done_c;
    logic              last_c;
    logic              ready_n, we_n, done_n, err_n;
    logic [31:0]       addr_n, wdata_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_n;
`endif

    assign accept = i_byte_valid && o_byte_ready;
    assign pk_en  = accept && (state_q == ST_DATA);
    assign n_full = {n_q[15:8], i_byte};

    word_packer u_packer (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .en          (pk_en),
        .byte_data   (i_byte),
        .word_c      (word_c),
        .word_done_c (word_done_c)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_n = state_q;
        n_n     = n_q;
        idx_n   = idx_q;
        we_n    = 1'b0;
        addr_n  = o_im_addr;
        wdata_n = o_im_wdata;
        last_c  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_n   = xor_q;
`endif
        case (state_q)
            ST_HDR0: begin
                if (accept) begin
                    n_n[15:8] = i_byte;
                    state_n   = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (accept) begin
                    n_n[7:0] = i_byte;
                    if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_n = ST_CHK;
`else
                        state_n = ST_DONE;
`endif
                    end else if (32'(n_full) > CAP_WORDS) begin
                        state_n = ST_ERR;
                    end else begin
                        state_n = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) begin
                    xor_n = xor_q ^ i_byte;
                end
`endif
                if (word_done_c) begin
                    we_n    = 1'b1;
                    addr_n  = 32'(idx_q) << 2;
                    wdata_n = word_c;
                    idx_n   = idx_q + IDX_W'(1);
                    if (32'(idx_q) + 32'd1 == 32'(n_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_n = ST_CHK;
`else
                        last_c  = 1'b1;
`endif
                    end
                end
`ifndef IMEM_LOADER_CHECKSUM_EN
                // Finish only once the final write has been presented.
                if (o_im_we && (32'(idx_q) == 32'(n_q))) begin
                    state_n = ST_DONE;
                end
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    state_n = (i_byte == xor_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: state_n = ST_DONE;
            ST_ERR:  state_n = ST_ERR;
            default: state_n = ST_HDR0;
        endcase

        ready_n = (state_n != ST_DONE) && (state_n != ST_ERR) && !last_c;
        done_n  = (state_n == ST_DONE);
        err_n   = (state_n == ST_ERR);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_HDR0;
            n_q          <= 16'd0;
            idx_q        <= '0;
            o_byte_ready <= 1'b0;
            o_im_we      <= 1'b0;
            o_im_addr    <= 32'd0;
            o_im_wdata   <= 32'd0;
            o_cpu_rst_n  <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            state_q      <= state_n;
            n_q          <= n_n;
            idx_q        <= idx_n;
            o_byte_ready <= ready_n;
            o_im_we      <= we_n;
            o_im_addr    <= addr_n;
            o_im_wdata   <= wdata_n;
            o_cpu_rst_n  <= done_n;
            o_done       <= done_n;
            o_err        <= err_n;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            xor_q <= XOR_SEED;
        end else begin
            xor_q <= xor_n;
        end
    end
`endif

endmodule
